// File: rtl/rhd_spi_sequencer.sv
// Frame sequencer for one RHD2132 SPI port: walks slots 0..NUM_SLOTS-1, shifts each
// selected 16-bit command out MSB-first and returns MISO words tagged with their channel.
module rhd_spi_sequencer #(
    parameter int NUM_SLOTS      = 35,
    parameter int CLK_DIV        = 1,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int AUX_AW         = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              settle_req,
    input  logic [AUX_AW-1:0] aux_loop_end,
    input  logic [15:0]       MOSI_cmd,
    output logic [5:0]        channel,
    output logic              DSP_settle,
    output logic [AUX_AW-1:0] aux_index,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [15:0]       rx_data,
    output logic [5:0]        rx_channel,
    output logic              rx_valid,
    output logic              frame_start,
    output logic              busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(CS_HIGH_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

    state_t            state_q;
    logic [5:0]        channel_q;
    logic              settle_q;
    logic [AUX_AW-1:0] aux_index_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              mosi_q;
    logic [14:0]       shreg_q;
    logic [14:0]       rxreg_q;
    logic [15:0]       rx_data_q;
    logic [5:0]        rx_channel_q;
    logic              rx_valid_q;
    logic              frame_start_q;
    logic [DIV_W-1:0]  div_q;
    logic [3:0]        bit_q;
    logic [GAP_W-1:0]  gap_q;
    logic [1:0]        warm_q;

    logic              gap_done;
    logic              last_slot;
    logic              start_frame;
    logic [AUX_AW-1:0] aux_index_d;
    logic [5:0]        rx_channel_d;
    logic [15:0]       rx_word_d;

    always_comb begin
        gap_done     = (state_q == ST_GAP) && (gap_q == GAP_W'(CS_HIGH_CYCLES - 1));
        last_slot    = (channel_q == 6'(NUM_SLOTS - 1));
        start_frame  = ((state_q == ST_IDLE) && run) || (gap_done && last_slot && run);
        // Natural overflow gives the wrap to 0 when the index is already past aux_loop_end.
        aux_index_d  = (aux_index_q == aux_loop_end) ? '0 : aux_index_q + 1'b1;
        // The RHD answers two commands late, so the word belongs to slot-2 (mod frame).
        rx_channel_d = (channel_q >= 6'd2) ? channel_q - 6'd2 : channel_q + 6'(NUM_SLOTS - 2);
        rx_word_d    = {rxreg_q, miso};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            channel_q     <= '0;
            settle_q      <= 1'b0;
            aux_index_q   <= '0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            shreg_q       <= '0;
            rxreg_q       <= '0;
            rx_data_q     <= '0;
            rx_channel_q  <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            div_q         <= '0;
            bit_q         <= '0;
            gap_q         <= '0;
            warm_q        <= '0;
        end else begin
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) warm_q <= '0;
                end
                ST_LOAD: begin
                    shreg_q <= MOSI_cmd[14:0];
                    mosi_q  <= MOSI_cmd[15];
                    div_q   <= '0;
                    bit_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            rxreg_q <= rx_word_d[14:0];
                            shreg_q <= {shreg_q[13:0], 1'b0};
                            if (bit_q == 4'd15) begin
                                state_q <= ST_GAP;
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                                gap_q   <= '0;
                                if (warm_q == 2'd2) begin
                                    rx_valid_q   <= 1'b1;
                                    rx_data_q    <= rx_word_d;
                                    rx_channel_q <= rx_channel_d;
                                end
                            end else begin
                                bit_q  <= bit_q + 4'd1;
                                mosi_q <= shreg_q[14];
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_done) begin
                        if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
                        if (last_slot) begin
                            aux_index_q <= aux_index_d;
                            if (!run) state_q <= ST_IDLE;
                        end else begin
                            channel_q <= channel_q + 6'd1;
                            cs_n_q    <= 1'b0;
                            state_q   <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Frame entry (from IDLE or wrap) overrides the per-state updates above.
            if (start_frame) begin
                state_q       <= ST_LOAD;
                channel_q     <= '0;
                cs_n_q        <= 1'b0;
                frame_start_q <= 1'b1;
                settle_q      <= settle_req;
            end
        end
    end

    assign channel     = channel_q;
    assign DSP_settle  = settle_q;
    assign aux_index   = aux_index_q;
    assign cs_n        = cs_n_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign rx_data     = rx_data_q;
    assign rx_channel  = rx_channel_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_rhd_spi_sequencer.sv
// Bench for rhd_spi_sequencer: an RHD model answers two commands late, a scoreboard
// queue holds the expected rx words and a monitor pops them on every rx_valid.
module tb_rhd_spi_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        settle_req;
    logic [9:0]  aux_loop_end;
    logic [15:0] MOSI_cmd;
    logic [5:0]  channel;
    logic        DSP_settle;
    logic [9:0]  aux_index;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [15:0] rx_data;
    logic [5:0]  rx_channel;
    logic        rx_valid;
    logic        frame_start;
    logic        busy;

    rhd_spi_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .settle_req(settle_req),
        .aux_loop_end(aux_loop_end), .MOSI_cmd(MOSI_cmd), .channel(channel),
        .DSP_settle(DSP_settle), .aux_index(aux_index), .cs_n(cs_n), .sclk(sclk),
        .mosi(mosi), .miso(miso), .rx_data(rx_data), .rx_channel(rx_channel),
        .rx_valid(rx_valid), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ch;
        logic [15:0] data;
    } rx_t;

    rx_t sb[$];
    rx_t mon_exp;
    int  n_chk = 0, n_ok = 0, mon_chk = 0, mon_ok = 0;
    int  cyc = 0;
    bit  const_mode = 1'b1;
    logic cs_prev = 1'b1, sclk_prev = 1'b0;
    int  exp_aux[4] = '{0, 1, 2, 0};
    int  exp_set[4] = '{0, 1, 0, 0};

    assign MOSI_cmd = const_mode ? 16'hA5C3 : {2'b00, channel, 8'h00};

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        cs_prev   <= cs_n;
        sclk_prev <= sclk;
    end

    // RHD model: records each command from mosi and replays the one from two slots back.
    logic [15:0] cap = '0, hist0 = '0, hist1 = '0;
    logic [4:0]  bit_idx = '0;
    always @(negedge clk) begin
        if (cs_prev && !cs_n) bit_idx <= '0;
        else if (sclk_prev && !sclk) bit_idx <= bit_idx + 5'd1;
        if (!sclk_prev && sclk) cap <= {cap[14:0], mosi};
        if (!cs_prev && cs_n) begin
            hist1 <= hist0;
            hist0 <= cap;
        end
    end
    assign miso = bit_idx[4] ? 1'b0 : hist1[4'd15 - bit_idx[3:0]];

    always @(negedge clk) begin
        if (rx_valid) begin
            mon_chk <= mon_chk + 1;
            if (sb.size() == 0) begin
                $display("FAIL rx_unexpected: got ch=%0d data=0x%04h, required no strobe", rx_channel, rx_data);
            end else begin
                mon_exp = sb.pop_front();
                if (rx_channel === mon_exp.ch && rx_data === mon_exp.data) begin
                    mon_ok <= mon_ok + 1;
                    $display("rx ch=%0d data=0x%04h ok", rx_channel, rx_data);
                end else begin
                    $display("FAIL rx_word: got ch=%0d data=0x%04h, required ch=%0d data=0x%04h",
                             rx_channel, rx_data, mon_exp.ch, mon_exp.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic push_run(input int nslots, input bit cmode);
        rx_t e;
        int  ch;
        for (int k = 2; k < nslots; k++) begin
            ch     = (k - 2) % 35;
            e.ch   = 6'(ch);
            e.data = cmode ? 16'hA5C3 : {2'b00, 6'(ch), 8'h00};
            sb.push_back(e);
        end
    endtask

    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_start && n < budget);
        chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic wait_chan(input int ch, input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (channel != 6'(ch) && n < budget);
        chk("channel_reached", {26'd0, channel}, ch);
    endtask

    task automatic count_to_idle(input int budget, output int falls);
        int n;
        n = 0;
        falls = 0;
        do begin
            @(negedge clk);
            n++;
            if (cs_prev && !cs_n) falls++;
        end while (busy && n < budget);
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t0, falls, nrise, n;
        logic [15:0] word;
        rst_n = 1'b0; run = 1'b0; settle_req = 1'b0; aux_loop_end = 10'd2;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_channel", {26'd0, channel}, 32'd0);
        chk("rst_aux", {22'd0, aux_index}, 32'd0);
        chk("rst_rx", {9'd0, rx_valid, rx_channel, rx_data}, 32'd0);
        chk("rst_fs_settle", {30'd0, frame_start, DSP_settle}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_run", {31'd0, busy}, 32'd0);

        // Constant command, one frame: latency, bit order, slot period.
        push_run(35, 1'b1);
        run = 1'b1;
        @(negedge clk);
        chk("cs_fall_latency", {31'd0, cs_n}, 32'd0);
        chk("first_frame_start", {31'd0, frame_start}, 32'd1);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        t0 = cyc;
        word = '0; nrise = 0; n = 0;
        while (nrise < 16 && n < 100) begin
            @(negedge clk);
            n++;
            if (!sclk_prev && sclk) begin
                word = {word[14:0], mosi};
                nrise++;
            end
        end
        chk("mosi_word", {16'd0, word}, 32'h0000A5C3);
        n = 0;
        do begin @(negedge clk); n++; end while (!(cs_prev && !cs_n) && n < 100);
        chk("slot_period", cyc - t0, 32'd37);
        run = 1'b0;
        count_to_idle(35 * 37, falls);
        chk("slots_after_drop", falls, 32'd33);
        chk("idle_cs_n", {31'd0, cs_n}, 32'd1);
        chk("idle_channel_hold", {26'd0, channel}, 32'd34);
        chk("aux_after_frame", {22'd0, aux_index}, 32'd1);

        // Two-late replay, aux wrap, settle sampling, run dropped at slot 10.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        const_mode = 1'b0;
        push_run(140, 1'b0);
        run = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_fs(1400);
            if (f > 0) chk("frame_period", cyc - t0, 32'd1295);
            t0 = cyc;
            chk("aux_at_frame", {22'd0, aux_index}, exp_aux[f]);
            chk("settle_at_frame", {31'd0, DSP_settle}, exp_set[f]);
            wait_chan(5, 300);
            if (f == 0) settle_req = 1'b1;
            else if (f == 1) settle_req = 1'b0;
            if (f == 3) begin
                wait_chan(10, 300);
                run = 1'b0;
                count_to_idle(35 * 37, falls);
                chk("slots_after_run_drop", falls, 32'd24);
                chk("end_cs_n", {31'd0, cs_n}, 32'd1);
            end else begin
                wait_chan(20, 700);
                chk("settle_mid_frame", {31'd0, DSP_settle}, exp_set[f]);
            end
        end

        // Reset during bit 7 of slot 2: nothing is reported, restart is from slot 0.
        run = 1'b1;
        wait_chan(2, 200);
        nrise = 0; n = 0;
        while (nrise < 8 && n < 40) begin
            @(negedge clk);
            n++;
            if (!sclk_prev && sclk) nrise++;
        end
        chk("bit7_reached", nrise, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cs_n", {31'd0, cs_n}, 32'd1);
        chk("async_sclk", {31'd0, sclk}, 32'd0);
        repeat (3) @(negedge clk);
        chk("held_rst_busy", {31'd0, busy}, 32'd0);
        push_run(35, 1'b0);
        rst_n = 1'b1;
        wait_fs(5);
        chk("restart_slot0", {26'd0, channel}, 32'd0);
        run = 1'b0;
        count_to_idle(35 * 37, falls);
        chk("restart_slots", falls, 32'd34);
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_ok + mon_ok, n_chk + mon_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
